alu_seq_ctrl: RTL

Parametrised ALU operation controller and sequencer that sits between instruction decode and the datapath ALU. It accepts an opcode and two operands over a valid/ready handshake and decodes the opcode to a 3-bit ALU function. Single-cycle functions finish in one cycle. MUL, SLLV and SRLV are multi-cycle operations, iterated one step per cycle. Each result is held until the consumer accepts it.

---
 rtl/alu_seq_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - ALU op decoder and sequencer with multi-cycle MUL/SLLV/SRLV
module alu_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       aluop_out,
  output logic             err,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [1:0]       r_kind;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_aluop;
  logic             r_err;

  logic             w_fire;
  logic             w_multi;
  logic             w_zero_shift;
  logic             w_last;
  logic [2:0]       w_aluop;
  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_a_next;

  assign in_ready     = (r_state == S_IDLE) && rst_n;
  assign w_fire       = in_valid && in_ready;
  // 1000 MUL, 1001 SLLV, 1010 SRLV; everything else with opcode[3] set is illegal
  assign w_multi      = opcode[3] && (opcode[2:0] <= 3'b010);
  assign w_zero_shift = (opcode[1:0] != 2'b00) && (b[SHW-1:0] == '0);
  assign w_last       = (r_cnt == CW'(1));
  assign w_aluop      = (opcode == 4'b0110) ? 3'b100 : opcode[2:0];

  always_comb begin
    w_alu_res = '0;
    case (w_aluop)
      3'b000:  w_alu_res = a + b;
      3'b001:  w_alu_res = a - b;
      3'b010:  w_alu_res = a & b;
      3'b011:  w_alu_res = a | b;
      3'b100:  w_alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      3'b101:  w_alu_res = a ^ b;
      3'b111:  w_alu_res = ~(a | b);
      default: w_alu_res = '0;
    endcase
  end

  // MUL shares the left shift of r_a as its multiplicand walk
  assign w_acc_next = r_b[0] ? (r_acc + r_a) : r_acc;
  assign w_a_next   = (r_kind == 2'b10) ? (r_a >> 1) : (r_a << 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_fire) w_next = (w_multi && !w_zero_shift) ? S_EXEC : S_DONE;
      S_EXEC: if (w_last) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_kind   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_aluop  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_fire) begin
          r_a    <= a;
          r_b    <= b;
          r_acc  <= '0;
          r_kind <= opcode[1:0];
          r_cnt  <= '0;
          if (!opcode[3]) begin
            r_result <= w_alu_res;
            r_aluop  <= w_aluop;
            r_err    <= 1'b0;
          end else if (!w_multi) begin
            r_result <= '0;
            r_aluop  <= 3'b000;
            r_err    <= 1'b1;
          end else if (opcode[1:0] == 2'b00) begin
            r_cnt <= CW'(WIDTH);
          end else if (w_zero_shift) begin
            r_result <= a;
            r_aluop  <= 3'b000;
            r_err    <= 1'b0;
          end else begin
            r_cnt <= {1'b0, b[SHW-1:0]};
          end
        end
        S_EXEC: begin
          r_cnt <= r_cnt - CW'(1);
          r_a   <= w_a_next;
          r_b   <= r_b >> 1;
          r_acc <= w_acc_next;
          if (w_last) begin
            r_result <= (r_kind == 2'b00) ? w_acc_next : w_a_next;
            r_aluop  <= 3'b000;
            r_err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;
  assign aluop_out = r_aluop;
  assign err       = r_err;

endmodule
